// File: rtl/vend_change_payout.sv
// vend_change_payout: pays change through 10 Rs / 5 Rs hoppers; optional per-denomination tally via PAYOUT_TALLY_EN
module vend_change_payout #(
  parameter int AMT_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             clr,
  input  logic             hop10_ack,
  input  logic             hop5_ack,
  input  logic             hop10_empty,
  input  logic             hop5_empty,
  output logic             eject10,
  output logic             eject5,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remaining
`ifdef PAYOUT_TALLY_EN
  ,
  output logic [15:0]      tally10,
  output logic [15:0]      tally5
`endif
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, SELECT, EJ10, EJ5, WAIT10, WAIT5, DONE, FAULT} state_t;
  state_t state;
  logic [TW-1:0] timer;
  wire expired = timer == TW'(TIMEOUT - 1);
  // single FSM; outputs are assigned on the transition into each state so they are registered Moore outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      eject10   <= 1'b0;
      eject5    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
      timer     <= '0;
`ifdef PAYOUT_TALLY_EN
      tally10   <= '0;
      tally5    <= '0;
`endif
    end else begin
      eject10 <= 1'b0;
      eject5  <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: if (req) begin
          remaining <= amount;
          busy      <= 1'b1;
          state     <= SELECT;
        end
        SELECT: if (remaining == '0) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end else if (remaining >= AMT_W'(2) && !hop10_empty) begin
          eject10 <= 1'b1;
          state   <= EJ10;
        end else if (!hop5_empty) begin
          eject5 <= 1'b1;
          state  <= EJ5;
        end else begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= FAULT;
        end
        EJ10: begin
          timer <= '0;
          state <= WAIT10;
        end
        EJ5: begin
          timer <= '0;
          state <= WAIT5;
        end
        WAIT10: if (hop10_ack) begin
          remaining <= remaining - AMT_W'(2);
          state     <= SELECT;
`ifdef PAYOUT_TALLY_EN
          tally10   <= tally10 + {15'd0, tally10 != 16'hFFFF};
`endif
        end else if (expired) begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= FAULT;
        end else timer <= timer + 1'b1;
        WAIT5: if (hop5_ack) begin
          remaining <= remaining - AMT_W'(1);
          state     <= SELECT;
`ifdef PAYOUT_TALLY_EN
          tally5    <= tally5 + {15'd0, tally5 != 16'hFFFF};
`endif
        end else if (expired) begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= FAULT;
        end else timer <= timer + 1'b1;
        DONE: state <= IDLE;
        FAULT: if (clr) begin
          err       <= 1'b0;
          remaining <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_change_payout.sv
// tb_vend_change_payout: directed self-checking bench for vend_change_payout
module tb_vend_change_payout;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, clr = 1'b0;
  logic [3:0] amount = '0;
  logic hop10_ack = 1'b0, hop5_ack = 1'b0, hop10_empty = 1'b0, hop5_empty = 1'b0;
  logic eject10, eject5, busy, done, err;
  logic [3:0] remaining;
`ifdef PAYOUT_TALLY_EN
  logic [15:0] tally10, tally5;
`endif
  int n_cmp = 0, n_bad = 0;
  int rem_log [64];
  vend_change_payout #(.AMT_W(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount), .clr(clr),
    .hop10_ack(hop10_ack), .hop5_ack(hop5_ack),
    .hop10_empty(hop10_empty), .hop5_empty(hop5_empty),
    .eject10(eject10), .eject5(eject5), .busy(busy), .done(done), .err(err),
    .remaining(remaining)
`ifdef PAYOUT_TALLY_EN
    , .tally10(tally10), .tally5(tally5)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [3:0] amt);
    amount = amt;
    req = 1'b1;
    tick;
    req = 1'b0;
  endtask
  // runs hoppers until done/err; acks arrive in the WAIT cycle after the one following each eject
  task automatic serve(input int max_cyc, input bit ack_on, output int n10, output int n5,
                       output int ndone, output int end_i, output int first_ej);
    logic q10, q5, d10, d5;
    q10 = 0; q5 = 0; d10 = 0; d5 = 0;
    n10 = 0; n5 = 0; ndone = 0; end_i = -1; first_ej = -1;
    for (int i = 0; i < max_cyc; i++) begin
      hop10_ack = d10;
      hop5_ack = d5;
      tick;
      rem_log[i] = int'(remaining);
      n10 += int'(eject10);
      n5 += int'(eject5);
      ndone += int'(done);
      if ((eject10 || eject5) && first_ej < 0) first_ej = i;
      d10 = q10; d5 = q5;
      q10 = ack_on & eject10;
      q5 = ack_on & eject5;
      if (done || err) begin
        end_i = i;
        break;
      end
    end
    hop10_ack = 1'b0;
    hop5_ack = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_cmp++;
    if ({eject10, eject5, busy, done, err, remaining} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 000000000", {eject10, eject5, busy, done, err, remaining});
    end
    rst = 1'b0;
    tick;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
  endtask
  task automatic test_basic;
    int n10, n5, nd, ei, fe;
    start(4'd3);
    n_cmp++;
    if (busy !== 1'b1 || remaining !== 4'd3) begin
      n_bad++; $display("FAIL basic_latch: busy %b rem %0d want 1 3", busy, remaining);
    end
    serve(60, 1'b1, n10, n5, nd, ei, fe);
    n_cmp++;
    if (fe !== 0) begin n_bad++; $display("FAIL basic_eject_latency: got %0d want 0", fe); end
    n_cmp++;
    if (n10 !== 1 || n5 !== 1) begin n_bad++; $display("FAIL basic_coins: n10 %0d n5 %0d want 1 1", n10, n5); end
    n_cmp++;
    if (rem_log[2] !== 1 || rem_log[5] !== 0) begin
      n_bad++; $display("FAIL basic_remaining: %0d %0d want 1 0", rem_log[2], rem_log[5]);
    end
    n_cmp++;
    if (ei !== 6 || nd !== 1 || busy !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL basic_done: at %0d n %0d busy %b err %b want 6 1 0 0", ei, nd, busy, err);
    end
`ifdef PAYOUT_TALLY_EN
    n_cmp++;
    if (tally10 !== 16'd1 || tally5 !== 16'd1) begin
      n_bad++; $display("FAIL tally: got %0d %0d want 1 1", tally10, tally5);
    end
`endif
    tick;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_after: done %b busy %b want 0 0", done, busy); end
  endtask
  task automatic test_hop10_empty;
    int n10, n5, nd, ei, fe;
    hop10_empty = 1'b1;
    start(4'd4);
    serve(80, 1'b1, n10, n5, nd, ei, fe);
    n_cmp++;
    if (n10 !== 0 || n5 !== 4 || nd !== 1 || err !== 1'b0) begin
      n_bad++; $display("FAIL empty10: n10 %0d n5 %0d done %0d err %b want 0 4 1 0", n10, n5, nd, err);
    end
    hop10_empty = 1'b0;
    tick;
  endtask
  task automatic test_both_empty;
    int n10, n5, nd, ei, fe;
    hop10_empty = 1'b1;
    hop5_empty = 1'b1;
    start(4'd2);
    serve(10, 1'b1, n10, n5, nd, ei, fe);
    n_cmp++;
    if (ei !== 0 || err !== 1'b1 || remaining !== 4'd2 || busy !== 1'b0 || n10 + n5 !== 0) begin
      n_bad++; $display("FAIL both_empty: at %0d err %b rem %0d busy %b ej %0d want 0 1 2 0 0", ei, err, remaining, busy, n10 + n5);
    end
    hop10_empty = 1'b0;
    hop5_empty = 1'b0;
    start(4'd7);
    tick;
    n_cmp++;
    if (err !== 1'b1 || remaining !== 4'd2 || eject10 !== 1'b0) begin
      n_bad++; $display("FAIL fault_req_ignored: err %b rem %0d ej %b want 1 2 0", err, remaining, eject10);
    end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    n_cmp++;
    if (err !== 1'b0 || remaining !== 4'd0) begin
      n_bad++; $display("FAIL clr: err %b rem %0d want 0 0", err, remaining);
    end
    start(4'd1);
    serve(40, 1'b1, n10, n5, nd, ei, fe);
    n_cmp++;
    if (nd !== 1 || n5 !== 1 || n10 !== 0) begin
      n_bad++; $display("FAIL after_clr: done %0d n5 %0d n10 %0d want 1 1 0", nd, n5, n10);
    end
    tick;
  endtask
  task automatic test_timeout;
    int n10, n5, nd, ei, fe;
    start(4'd1);
    serve(40, 1'b0, n10, n5, nd, ei, fe);
    n_cmp++;
    if (ei !== 17 || err !== 1'b1 || remaining !== 4'd1 || n5 !== 1) begin
      n_bad++; $display("FAIL timeout: at %0d err %b rem %0d n5 %0d want 17 1 1 1", ei, err, remaining, n5);
    end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    start(4'd1);
    for (int i = 0; i < 17; i++) tick;
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL timeout_early: err %b busy %b want 0 1", err, busy); end
    hop5_ack = 1'b1;
    tick;
    hop5_ack = 1'b0;
    n_cmp++;
    if (err !== 1'b0 || remaining !== 4'd0) begin
      n_bad++; $display("FAIL ack_at_expiry: err %b rem %0d want 0 0", err, remaining);
    end
    tick;
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL expiry_done: done %b err %b want 1 0", done, err); end
    tick;
  endtask
  task automatic test_rst_mid;
    start(4'd5);
    tick;
    n_cmp++;
    if (eject10 !== 1'b1) begin n_bad++; $display("FAIL mid_eject10: got %b want 1", eject10); end
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if ({eject10, eject5, busy, done, err, remaining} !== 9'd0) begin
      n_bad++; $display("FAIL mid_reset: got %b want 000000000", {eject10, eject5, busy, done, err, remaining});
    end
    hop10_ack = 1'b1;
    tick;
    tick;
    hop10_ack = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || remaining !== 4'd0 || eject10 !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL stray_ack: busy %b rem %0d ej %b done %b want 0 0 0 0", busy, remaining, eject10, done);
    end
  endtask
  task automatic test_zero;
    start(4'd0);
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL zero_early: done %b want 0", done); end
    tick;
    n_cmp++;
    if (done !== 1'b1 || eject10 !== 1'b0 || eject5 !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_done: done %b ej %b%b busy %b want 1 00 0", done, eject10, eject5, busy);
    end
    tick;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL zero_pulse: done %b want 0", done); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_hop10_empty;
    test_both_empty;
    test_timeout;
    test_rst_mid;
    test_zero;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vend_change_payout.md
Name: vend_change_payout

Overview:
- Payout controller for the water vending machine; the dispensing end of the coin path.
- Takes a change amount in 5 Rs units from the vend FSM.
- Drives the 10 Rs and 5 Rs coin hoppers with a pulse/ack handshake until the amount is paid.
- Reports done, or a sticky fault when a hopper is empty or stalls.

Parameters:
- AMT_W, 4, width of amount/remaining in 5 Rs units (max 15 units = 75 Rs)
- TIMEOUT, 16, cycles allowed in a WAIT state for a hopper ack before FAULT; minimum 2

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req  input  1  payout request; sampled only in IDLE
- amount  input  AMT_W  change to pay, in 5 Rs units; latched with req
- clr  input  1  clears FAULT, returns to IDLE
- hop10_ack  input  1  10 Rs hopper: coin dropped
- hop5_ack  input  1  5 Rs hopper: coin dropped
- hop10_empty  input  1  10 Rs hopper has no coins
- hop5_empty  input  1  5 Rs hopper has no coins
- eject10  output  1  one-cycle pulse: drop one 10 Rs coin
- eject5  output  1  one-cycle pulse: drop one 5 Rs coin
- busy  output  1  payout in progress
- done  output  1  one-cycle pulse: payout complete
- err  output  1  sticky fault flag
- remaining  output  AMT_W  unpaid units

Behaviour:
- Reset (synchronous, any state, including mid-payout):
  - state IDLE
  - eject10 = eject5 = busy = done = err = 0; remaining = 0; timer = 0
- All outputs are registered Moore outputs of the state.
- Eject pulse is never repeated until the matching ack arrives or FAULT is entered.
- IDLE:
  - req=1 latches remaining<=amount, goes to SELECT, busy=1 from the next cycle.
  - req=0 stays in IDLE.
- SELECT, priority order:
  - remaining==0 -> DONE
  - remaining>=2 and !hop10_empty -> EJ10
  - !hop5_empty -> EJ5 (covers remaining==1, and remaining>=2 with the 10 Rs hopper empty)
  - otherwise -> FAULT
- EJ10 / EJ5:
  - The matching eject is high for exactly this one cycle; timer cleared.
  - Always moves to WAIT10 / WAIT5.
- WAIT10 / WAIT5:
  - Matching ack=1 -> remaining -= 2 (10 Rs) or 1 (5 Rs), then SELECT.
  - Otherwise timer++. When timer reaches TIMEOUT-1 with no ack -> FAULT.
  - An ack on the cycle the timer expires wins; the coin is counted.
- Stray acks (any state other than the matching WAIT, including the EJ cycle and the other hopper's ack) are ignored.
- Underflow is impossible: 10 Rs is selected only when remaining>=2.
- DONE: done=1 for one cycle, busy=0, then IDLE. req in the DONE cycle is ignored.
- FAULT:
  - err=1, busy=0; remaining holds the unpaid units.
  - req is ignored.
  - clr=1 -> IDLE with err=0, remaining=0.
  - clr in any other state has no effect.
- Latency:
  - req at edge k: eject asserted during cycle k+2.
  - amount=0: done pulse during cycle k+2.
- Simultaneous rst and clr/req: rst wins.

Optional Feature:
- Macro: PAYOUT_TALLY_EN
- Defined:
  - Adds outputs tally10[15:0] and tally5[15:0], counting acked coins per denomination.
  - Counters saturate at 16'hFFFF; cleared only by rst, not by clr.
  - tally increments in the same cycle remaining decrements.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- amount=3, both hoppers full, acks 1 cycle after each eject -> one eject10 then one eject5; remaining 3->1->0; done pulse; busy low after.
- amount=4, hop10_empty=1 -> four eject5 pulses; eject10 never asserted; done.
- amount=2, hop10_empty=1, hop5_empty=1 -> FAULT with no eject; err=1, remaining=2; clr -> err=0, IDLE; next req accepted.
- amount=1, no hop5_ack, TIMEOUT=16 -> eject5 once, FAULT when the timer reaches 15, remaining=1; ack on the expiry cycle instead -> done, no err.
- rst asserted in WAIT10 with amount=5 -> next cycle all outputs 0, IDLE; a later ack is ignored.
- amount=0 -> done during cycle k+2 with no eject; with PAYOUT_TALLY_EN, the amount=3 case gives tally10=1, tally5=1.
